seq_signed_multiplier: RTL and testbench

//   Iterative 32x32 -> 64-bit signed multiplier for the lab ALU path. Sits

---
 rtl/seq_signed_multiplier.sv | 135 +++++++++++++
 tb/tb_seq_signed_multiplier.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_multiplier.sv
// seq_signed_multiplier
//   Iterative 32x32 -> 64-bit multiplier with one shift-add step per clock.
//   Signed operands are reduced to magnitudes on the start cycle and the
//   result sign is restored by a 64-bit negation in a final fix-up cycle.
//   The operation takes 33 clocks from the accepted start to the done pulse.
// Parameters
//   SIGNED   1: two's-complement operands; 0: unsigned, sign logic bypassed
//   ITERS    iteration count; only 32 is supported
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset
//   start    request, sampled only while idle
//   a, b     multiplicand / multiplier, latched on an accepted start
//   busy     high while an operation is in progress
//   done     one-cycle pulse; product valid from this cycle on
//   product  64-bit result, held until the next done or reset
module seq_signed_multiplier #(
  parameter bit          SIGNED = 1'b1,
  parameter int unsigned ITERS  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  localparam int unsigned CntW = $clog2(ITERS) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e            state_q, state_d;
  logic [31:0]       mcand_q, mcand_d;
  logic [31:0]       mplr_q, mplr_d;
  logic [31:0]       acc_hi_q, acc_hi_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_res_q, neg_res_d;
  logic              done_q, done_d;
  logic [63:0]       product_q, product_d;

  logic              a_neg, b_neg;
  logic [31:0]       a_mag, b_mag;
  logic [32:0]       sum;
  logic [63:0]       full;
  logic [63:0]       fixed;
  logic              last_iter;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Operand magnitudes. neg32(32'h80000000) returns itself, which read as
  // unsigned is the correct magnitude 2^31.
  assign a_neg = SIGNED && a[31];
  assign b_neg = SIGNED && b[31];
  assign a_mag = a_neg ? neg32(a) : a;
  assign b_mag = b_neg ? neg32(b) : b;

  // The 33-bit sum keeps the carry; it shifts into acc_hi/mplr as one
  // 65-bit right shift so no bit is lost.
  assign sum       = {1'b0, acc_hi_q} + {1'b0, (mplr_q[0] ? mcand_q : 32'd0)};
  assign full      = {acc_hi_q, mplr_q};
  assign fixed     = neg_res_q ? (~full + 64'd1) : full;
  assign last_iter = (cnt_q == CntW'(ITERS - 1));

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_hi_d  = acc_hi_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    done_d    = 1'b0;
    product_d = product_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d   = a_mag;
          mplr_d    = b_mag;
          neg_res_d = a_neg ^ b_neg;
          acc_hi_d  = 32'd0;
          cnt_d     = '0;
          state_d   = StCalc;
        end
      end
      StCalc: begin
        acc_hi_d = sum[32:1];
        mplr_d   = {sum[0], mplr_q[31:1]};
        cnt_d    = cnt_q + CntW'(1);
        if (last_iter) begin
          state_d = StFix;
        end
      end
      StFix: begin
        product_d = fixed;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      mcand_q   <= 32'd0;
      mplr_q    <= 32'd0;
      acc_hi_q  <= 32'd0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      done_q    <= 1'b0;
      product_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_hi_q  <= acc_hi_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Directed bench for seq_signed_multiplier: a signed instance and an
// unsigned instance share clock, reset and operands; each has its own start.
module tb_seq_signed_multiplier;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_s = 1'b0;
  logic        start_u = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy_s, done_s, busy_u, done_u;
  logic [63:0] product_s, product_u;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_signed_multiplier #(.SIGNED(1'b1), .ITERS(32)) dut_s (
    .clk     (clk),
    .reset   (reset),
    .start   (start_s),
    .a       (a),
    .b       (b),
    .busy    (busy_s),
    .done    (done_s),
    .product (product_s)
  );

  seq_signed_multiplier #(.SIGNED(1'b0), .ITERS(32)) dut_u (
    .clk     (clk),
    .reset   (reset),
    .start   (start_u),
    .a       (a),
    .b       (b),
    .busy    (busy_u),
    .done    (done_u),
    .product (product_u)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts edges until done is seen 1 ns after an edge; bounded at 100.
  task automatic wait_done(input bit uns, output int cycles);
    cycles = 0;
    while (cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
      if (uns ? done_u : done_s) break;
    end
  endtask

  // Called 1 ns after an edge; returns 1 ns after the edge that raised done.
  task automatic run_op(input bit uns, input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] exp, input string tag);
    int cyc;
    if (uns) start_u = 1'b1;
    else     start_s = 1'b1;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    start_u = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    check({tag, " busy_rise"}, 64'(uns ? busy_u : busy_s), 64'd1);
    wait_done(uns, cyc);
    check({tag, " latency"}, 64'(cyc), 64'd33);
    check({tag, " product"}, uns ? product_u : product_s, exp);
    check({tag, " busy_fall"}, 64'(uns ? busy_u : busy_s), 64'd0);
  endtask

  initial begin
    int cyc;
    int done_seen;

    // Reset state
    #20;
    reset = 1'b0;
    check("reset busy", 64'(busy_s), 64'd0);
    check("reset done", 64'(done_s), 64'd0);
    check("reset product", product_s, 64'd0);
    @(posedge clk);
    #1;

    // 3 * 5, then back-to-back -1 * -1 started in the done cycle
    run_op(1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F, "mul_3x5");
    start_s = 1'b1;
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    check("b2b done_fall", 64'(done_s), 64'd0);
    check("b2b busy_rise", 64'(busy_s), 64'd1);
    check("b2b product_hold", product_s, 64'h0000_0000_0000_000F);
    wait_done(1'b0, cyc);
    check("b2b latency", 64'(cyc), 64'd33);
    check("b2b product", product_s, 64'd1);

    // -2 * 7, then done must last a single cycle with product held
    @(posedge clk);
    #1;
    run_op(1'b0, 32'hFFFF_FFFE, 32'd7, 64'hFFFF_FFFF_FFFF_FFF2, "mul_m2x7");
    @(posedge clk);
    #1;
    check("pulse done_fall", 64'(done_s), 64'd0);
    check("pulse product_hold", product_s, 64'hFFFF_FFFF_FFFF_FFF2);

    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "mul_min");
    @(posedge clk);
    #1;
    run_op(1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 64'd12, "mul_m3xm4");
    @(posedge clk);
    #1;
    run_op(1'b0, 32'd7, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, "mul_7xm1");
    @(posedge clk);
    #1;

    // Start re-pulsed mid-operation must be ignored
    start_s = 1'b1;
    a = 32'd2;
    b = 32'd3;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    start_s = 1'b1;
    a = 32'd9;
    b = 32'd9;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    check("ignore busy", 64'(busy_s), 64'd1);
    wait_done(1'b0, cyc);
    check("ignore latency", 64'(10 + cyc), 64'd33);
    check("ignore product", product_s, 64'd6);
    @(posedge clk);
    #1;

    // Reset mid-operation discards it
    start_s = 1'b1;
    a = 32'd5;
    b = 32'd5;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort busy", 64'(busy_s), 64'd0);
    check("abort done", 64'(done_s), 64'd0);
    check("abort product", product_s, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done_s || busy_s) done_seen++;
    end
    check("abort quiet", 64'(done_seen), 64'd0);
    run_op(1'b0, 32'd0, 32'hFFFF_FFFF, 64'd0, "mul_0xm1");
    @(posedge clk);
    #1;

    // Unsigned build
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "umul_max");
    @(posedge clk);
    #1;
    run_op(1'b1, 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, "umul_msb");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
